instr_encoder: RTL and testbench

Packs host-supplied instruction fields into SIMD instruction words and writes them sequentially into instruction memory. It is the producer for the instruction decoder, sitting between the host/loader command stream and the instruction-memory write port. Commands arrive over a valid/ready handshake, are checked for legal opcodes and buffered in a small FIFO. A program is closed by a `last` command, after which the block reports the program length.

---
 rtl/instr_encoder.sv | 142 ++++++++++++++
 tb/tb_instr_encoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs host command fields into SIMD instruction words, buffers them in a small
// FIFO and writes them sequentially into instruction memory, one program at a time.
module instr_encoder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int OPCODE_WIDTH    = 3,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int INS_WIDTH       = OPCODE_WIDTH + 3*ADDR_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OPCODE_WIDTH-1:0]    cmd_opcode,
  input  logic [ADDR_WIDTH-1:0]      cmd_a_addr,
  input  logic [ADDR_WIDTH-1:0]      cmd_b_addr,
  input  logic [ADDR_WIDTH-1:0]      cmd_r_addr,
  input  logic                       cmd_shift,
  input  logic                       cmd_last,
  output logic                       ins_we,
  output logic [IMEM_ADDR_WIDTH-1:0] ins_waddr,
  output logic [INS_WIDTH-1:0]       ins_wdata,
  output logic                       prog_done,
  output logic [IMEM_ADDR_WIDTH:0]   prog_len,
  output logic                       err_opcode,
  output logic                       err_overflow,
  output logic                       busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = IMEM_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {IMEM_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [INS_WIDTH-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]             count_q, count_d;
  logic [CNT_W-1:0]           push_cnt_q, push_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                       ins_we_q, ins_we_d;
  logic [IMEM_ADDR_WIDTH-1:0] ins_waddr_q, ins_waddr_d;
  logic [INS_WIDTH-1:0]       ins_wdata_q, ins_wdata_d;
  logic [CNT_W-1:0]           prog_len_q, prog_len_d;
  logic                       err_opcode_q, err_opcode_d, err_overflow_q, err_overflow_d;

  logic                 fifo_full, fifo_empty, hs, legal, room, push, pop;
  logic [INS_WIDTH-1:0] cmd_word;

  always_comb begin
    fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    // cmd_ready comes from registered state only; rst just masks it while held.
    cmd_ready  = (state_q == S_LOAD) && !fifo_full && !rst;
    hs         = cmd_valid && cmd_ready;
    legal      = (cmd_opcode <= OPCODE_WIDTH'(4));
    room       = (push_cnt_q != MAX_WORDS);
    push       = hs && legal && room;
    pop        = !fifo_empty;
    cmd_word   = {cmd_opcode, cmd_a_addr, cmd_b_addr, cmd_r_addr, cmd_shift};

    state_d        = state_q;
    wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d       = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d        = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    push_cnt_d     = push ? push_cnt_q + 1'b1 : push_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    ins_we_d       = pop;
    ins_waddr_d    = ins_waddr_q;
    ins_wdata_d    = ins_wdata_q;
    prog_len_d     = prog_len_q;
    err_opcode_d   = err_opcode_q   || (hs && !legal);
    err_overflow_d = err_overflow_q || (hs && legal && !room);

    if (pop) begin
      ins_waddr_d = wr_cnt_q[IMEM_ADDR_WIDTH-1:0];
      ins_wdata_d = fifo_mem[rd_ptr_q];
      wr_cnt_d    = wr_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_LOAD:  if (hs && cmd_last) state_d = S_FLUSH;
      // An empty FIFO here means the final word (if any) is on the write port now.
      S_FLUSH: if (fifo_empty) begin
        state_d    = S_DONE;
        prog_len_d = wr_cnt_q;
      end
      S_DONE: begin
        state_d     = S_LOAD;
        wr_cnt_d    = '0;
        push_cnt_d  = '0;
        ins_waddr_d = '0;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_LOAD;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      push_cnt_q     <= '0;
      wr_cnt_q       <= '0;
      ins_we_q       <= 1'b0;
      ins_waddr_q    <= '0;
      ins_wdata_q    <= '0;
      prog_len_q     <= '0;
      err_opcode_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      push_cnt_q     <= push_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      ins_we_q       <= ins_we_d;
      ins_waddr_q    <= ins_waddr_d;
      ins_wdata_q    <= ins_wdata_d;
      prog_len_q     <= prog_len_d;
      err_opcode_q   <= err_opcode_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_word;
  end

  assign ins_we       = ins_we_q;
  assign ins_waddr    = ins_waddr_q;
  assign ins_wdata    = ins_wdata_q;
  assign prog_done    = (state_q == S_DONE);
  assign prog_len     = prog_len_q;
  assign err_opcode   = err_opcode_q;
  assign err_overflow = err_overflow_q;
  assign busy         = (state_q != S_LOAD);

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder: a program-level reference model
// queues expected writes and lengths; a monitor checks whatever the DUT emits.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode = '0;
  logic [9:0]  cmd_a_addr = '0, cmd_b_addr = '0, cmd_r_addr = '0;
  logic        cmd_shift = 1'b0, cmd_last = 1'b0;
  logic        ins_we;
  logic [7:0]  ins_waddr;
  logic [33:0] ins_wdata;
  logic        prog_done;
  logic [8:0]  prog_len;
  logic        err_opcode, err_overflow, busy;

  instr_encoder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr),
    .cmd_r_addr(cmd_r_addr), .cmd_shift(cmd_shift), .cmd_last(cmd_last),
    .ins_we(ins_we), .ins_waddr(ins_waddr), .ins_wdata(ins_wdata),
    .prog_done(prog_done), .prog_len(prog_len), .err_opcode(err_opcode),
    .err_overflow(err_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int          compared = 0, mismatched = 0, stalls = 0;
  int          exp_addr[$];
  logic [33:0] exp_data[$];
  int          exp_len[$];
  int          m_cnt = 0, m_last_len = 0;
  bit          m_opc = 0, m_ovf = 0;
  logic [33:0] last_wdata = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: program-level bookkeeping straight from the packing rules.
  function automatic void model_accept(logic [2:0] op, logic [9:0] a, b, r, logic sh, logic last);
    logic [33:0] w;
    w = (34'(op) << 31) + (34'(a) << 21) + (34'(b) << 11) + (34'(r) << 1) + 34'(sh);
    if (op < 3'd5) begin
      if (m_cnt < 256) begin
        exp_addr.push_back(m_cnt);
        exp_data.push_back(w);
        m_cnt++;
      end else m_ovf = 1;
    end else m_opc = 1;
    if (last) begin
      exp_len.push_back(m_cnt);
      m_last_len = m_cnt;
      m_cnt = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (ins_we) begin
        last_wdata = ins_wdata;
        if (exp_addr.size() == 0) chk("unexpected_write", 64'(ins_we), 64'd0);
        else begin
          chk("waddr", 64'(ins_waddr), 64'(exp_addr.pop_front()));
          chk("wdata", 64'(ins_wdata), 64'(exp_data.pop_front()));
        end
      end
      if (prog_done) begin
        if (exp_len.size() == 0) chk("unexpected_done", 64'(prog_done), 64'd0);
        else chk("prog_len", 64'(prog_len), 64'(exp_len.pop_front()));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(logic [2:0] op, logic [9:0] a, b, r, logic sh, logic last);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a_addr = a; cmd_b_addr = b;
    cmd_r_addr = r; cmd_shift = sh; cmd_last = last;
    for (int w = 0; w < 200 && !ok; w++) begin
      if (cmd_ready) ok = 1; else stalls++;
      @(posedge clk);
      @(negedge clk);
    end
    if (ok) model_accept(op, a, b, r, sh, last);
    else chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(int n);
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    cmd_valid = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_addr.size() == 0 && exp_len.size() == 0 && !busy && !ins_we) break;
    end
    chk("drain_pending", 64'(exp_addr.size() + exp_len.size()), 64'd0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_addr.delete(); exp_data.delete(); exp_len.delete();
    m_cnt = 0; m_opc = 0; m_ovf = 0;
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_outs", {ins_we, ins_waddr, ins_wdata, prog_done, prog_len,
                     err_opcode, err_overflow, busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    send(3'd0, 10'd1, 10'd2, 10'd3, 1'b0, 1'b1);
    wait_idle();
    chk("add_word", 64'(last_wdata), 64'h0_0020_1006);

    send(3'd3, 10'd5, 10'd6, 10'd7, 1'b1, 1'b1);
    wait_idle();
    chk("dot_word", 64'(last_wdata), 64'h1_80A0_300F);

    send(3'd0, 10'd9, 10'd9, 10'd9, 1'b0, 1'b0);
    send(3'd6, 10'd1, 10'd1, 10'd1, 1'b0, 1'b0);
    send(3'd1, 10'd4, 10'd4, 10'd4, 1'b1, 1'b1);
    wait_idle();
    chk("err_opcode_set", 64'(err_opcode), 64'd1);

    stalls = 0;
    for (int i = 0; i < 10; i++)
      send(3'($urandom_range(0, 4)), 10'($urandom), 10'($urandom), 10'($urandom),
           1'($urandom), i == 9);
    chk("burst_stalls", 64'(stalls), 64'd0);
    wait_idle();
    chk("err_opcode_sticky", 64'(err_opcode), 64'd1);
    chk("prog_len_hold", 64'(prog_len), 64'd10);

    for (int p = 0; p < 6; p++) begin
      int n = $urandom_range(1, 25);
      for (int i = 0; i < n; i++) begin
        send(3'($urandom_range(0, 7)), 10'($urandom), 10'($urandom), 10'($urandom),
             1'($urandom), i == n - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      wait_idle();
    end
    chk("err_opcode_rand", 64'(err_opcode), 64'(m_opc));
    chk("err_overflow_rand", 64'(err_overflow), 64'd0);

    for (int i = 0; i < 260; i++)
      send(3'($urandom_range(0, 4)), 10'($urandom), 10'($urandom), 10'($urandom),
           1'($urandom), i == 259);
    wait_idle();
    chk("err_overflow_set", 64'(err_overflow), 64'd1);
    chk("ovf_prog_len", 64'(prog_len), 64'(m_last_len));
    send(3'd2, 10'd11, 10'd12, 10'd13, 1'b0, 1'b0);
    send(3'd4, 10'd21, 10'd22, 10'd23, 1'b1, 1'b1);
    wait_idle();

    for (int i = 0; i < 3; i++)
      send(3'($urandom_range(0, 4)), 10'($urandom), 10'($urandom), 10'($urandom), 1'b0, 1'b0);
    do_reset();
    chk("err_opcode_cleared", 64'(err_opcode), 64'd0);
    chk("err_overflow_cleared", 64'(err_overflow), 64'd0);
    send(3'd1, 10'd100, 10'd200, 10'd300, 1'b0, 1'b0);
    send(3'd0, 10'd7, 10'd8, 10'd9, 1'b1, 1'b1);
    wait_idle();
    chk("post_rst_len", 64'(prog_len), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
